// File: rtl/instr_decode_stage_if.sv
// Fetch -> decode -> execute bus for instr_decode_stage.
//   fetch side   : in_valid/in_ready handshake carrying in_instr, in_pc
//   execute side : out_valid/out_ready handshake carrying out_pc, decoded
//                  fields, control bits and the dispatched-instruction count
// slave modport is the decode stage; master modport is its environment.
interface instr_decode_stage_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned CNT_W   = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [5:0]         opcode;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic [4:0]         shamt;
  logic [5:0]         funct;
  logic [IMM_W-1:0]   imm_out;
  logic               imm_signed;
  logic               alu_src_imm;
  logic [CNT_W-1:0]   disp_count;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
           imm_out, imm_signed, alu_src_imm, disp_count
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
           imm_out, imm_signed, alu_src_imm, disp_count
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Decode-stage pipeline register between fetch and execute.
// Words are buffered in a 2-entry skid buffer (main entry drives the outputs,
// skid entry absorbs one word of backpressure) so in_ready can be registered
// without losing throughput.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous reset, active low
//   flush   : synchronous flush, empties both entries
//   bus     : fetch/execute handshakes and decoded outputs (slave modport)
module instr_decode_stage #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  instr_decode_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Control bits are decoded on entry so the outputs come straight from flops.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               imm_signed;
    logic               alu_src_imm;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_entry;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             dispatch;
  logic [5:0]       new_op;

  // Decode the incoming word into a buffer entry.
  always_comb begin
    new_op                = bus.in_instr[31:26];
    new_entry.instr       = bus.in_instr;
    new_entry.pc          = bus.in_pc;
    new_entry.imm_signed  = !(new_op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F});
    new_entry.alu_src_imm = !(new_op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05});
  end

  assign accept   = bus.in_valid & in_ready_q;
  assign dispatch = out_valid_q & bus.out_ready;

  // Next-state and buffer steering; an empty entry is always held at zero.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q + CNT_W'(dispatch);

    if (flush) begin
      // A same-cycle offer is dropped; a same-cycle dispatch still counts.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = new_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !dispatch) begin
            skid_d  = new_entry;
            state_d = ST_TWO;
          end else if (!accept && dispatch) begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end else if (accept && dispatch) begin
            main_d  = new_entry;
          end
        end
        ST_TWO: begin
          if (dispatch) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end

    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = main_q.pc;
  assign bus.opcode      = main_q.instr[31:26];
  assign bus.rs          = main_q.instr[25:21];
  assign bus.rt          = main_q.instr[20:16];
  assign bus.rd          = main_q.instr[15:11];
  assign bus.shamt       = main_q.instr[10:6];
  assign bus.funct       = main_q.instr[5:0];
  assign bus.imm_out     = main_q.instr[IMM_W-1:0];
  assign bus.imm_signed  = main_q.imm_signed;
  assign bus.alu_src_imm = main_q.alu_src_imm;
  assign bus.disp_count  = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_instr_decode_stage;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned CNT_W   = 32;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  instr_decode_stage_if #(.INSTR_W(INSTR_W), .PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

  instr_decode_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of at most two words, plus ready flag and count.
  logic [31:0] mq_i[$];
  logic [31:0] mq_p[$];
  logic        m_ready = 1'b0;
  logic [31:0] m_cnt   = 32'd0;

  function automatic logic ref_imm_signed(input logic [31:0] instr);
    int op;
    op = int'(instr >> 26);
    return !(op >= 12 && op <= 15);
  endfunction

  function automatic logic ref_alu_imm(input logic [31:0] instr);
    int op;
    op = int'(instr >> 26);
    return !(op == 0 || op == 2 || op == 3 || op == 4 || op == 5);
  endfunction

  // Advance one clock edge with the current inputs and update the model.
  task automatic tick();
    logic acc, disp;
    @(posedge clk);
    if (!reset_n) begin
      mq_i.delete(); mq_p.delete();
      m_ready = 1'b0;
      m_cnt   = 32'd0;
    end else begin
      acc  = bus.in_valid && m_ready && !flush;
      disp = (mq_i.size() > 0) && bus.out_ready;
      if (disp) begin
        void'(mq_i.pop_front()); void'(mq_p.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (flush) begin
        mq_i.delete(); mq_p.delete();
      end else if (acc) begin
        mq_i.push_back(bus.in_instr); mq_p.push_back(bus.in_pc);
      end
      m_ready = (mq_i.size() < 2);
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h2128FFFC;
    bus.in_pc    = 32'h40;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.disp_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.disp_count); end
    checks++; if ({bus.out_pc, bus.opcode, bus.imm_out} !== '0) begin errors++; $display("FAIL reset_fields got pc=%h op=%h imm=%h exp=0", bus.out_pc, bus.opcode, bus.imm_out); end
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_decode();
    do_reset();
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h2128FFFC;
    bus.in_pc     = 32'h100;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.opcode !== 6'h08 || bus.rs !== 5'd9 || bus.rt !== 5'd8) begin
      errors++; $display("FAIL addi_regs got op=%h rs=%0d rt=%0d exp op=08 rs=9 rt=8", bus.opcode, bus.rs, bus.rt); end
    checks++; if (bus.imm_out !== 16'hFFFC) begin errors++; $display("FAIL addi_imm got=%h exp=fffc", bus.imm_out); end
    checks++; if (bus.imm_signed !== 1'b1 || bus.alu_src_imm !== 1'b1) begin
      errors++; $display("FAIL addi_ctrl got signed=%b aluimm=%b exp 1 1", bus.imm_signed, bus.alu_src_imm); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got=%h exp=100", bus.out_pc); end
    tick();
    checks++; if (bus.disp_count !== 32'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL addi_dispatch got cnt=%0d valid=%b exp cnt=1 valid=0", bus.disp_count, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic [31:0] words[3];
    int sent;
    words[0] = 32'h20010001; words[1] = 32'h20020002; words[2] = 32'h20030003;
    do_reset();
    sent = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1; bus.in_instr = words[sent]; bus.in_pc = 32'h200 + 32'(sent * 4);
      tick(); sent++;
    end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", bus.in_ready); end
    bus.in_instr = words[2]; bus.in_pc = 32'h208;
    tick(); tick();
    checks++; if (bus.out_pc !== 32'h200 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall got pc=%h ready=%b exp pc=200 ready=0", bus.out_pc, bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) got.push_back(bus.out_pc);
      if (bus.in_valid && bus.in_ready) begin
        tick(); bus.in_valid = 1'b0;
      end else tick();
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_drain_count got=%0d exp=3", got.size()); end
    else if (got[0] !== 32'h200 || got[1] !== 32'h204 || got[2] !== 32'h208) begin
      errors++; $display("FAIL bp_order got %h %h %h exp 200 204 208", got[0], got[1], got[2]); end
    checks++; if (bus.disp_count !== 32'd3) begin errors++; $display("FAIL bp_disp_count got=%0d exp=3", bus.disp_count); end
  endtask

  task automatic test_streaming();
    int n_disp, first, last, bad_order, not_ready;
    do_reset();
    n_disp = 0; first = -1; last = -1; bad_order = 0; not_ready = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 110; c++) begin
      if (bus.out_valid) begin
        if (bus.out_pc !== 32'(n_disp)) bad_order++;
        if (first < 0) first = c;
        last = c;
        n_disp++;
      end
      if (c < 100) begin
        if (bus.in_ready !== 1'b1) not_ready++;
        bus.in_valid = 1'b1; bus.in_pc = 32'(c); bus.in_instr = $urandom;
      end else bus.in_valid = 1'b0;
      tick();
    end
    checks++; if (n_disp != 100 || last - first != 99) begin
      errors++; $display("FAIL stream_rate got disp=%0d span=%0d exp disp=100 span=99", n_disp, last - first); end
    checks++; if (bad_order != 0 || not_ready != 0) begin
      errors++; $display("FAIL stream_order got misordered=%0d stalls=%0d exp 0 0", bad_order, not_ready); end
    checks++; if (bus.disp_count !== 32'd100) begin errors++; $display("FAIL stream_count got=%0d exp=100", bus.disp_count); end
  endtask

  task automatic test_flush();
    int seen;
    do_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1; bus.in_instr = 32'h24000000 + 32'(c); bus.in_pc = 32'h300 + 32'(c); tick();
    end
    flush = 1'b1; bus.in_instr = 32'h2400BEEF; bus.in_pc = 32'hDEAD;
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_pc !== 32'h0) begin
      errors++; $display("FAIL flush_state got valid=%b ready=%b pc=%h exp 0 1 0", bus.out_valid, bus.in_ready, bus.out_pc); end
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin if (bus.out_valid) seen++; tick(); end
    checks++; if (seen != 0 || bus.disp_count !== 32'd0) begin
      errors++; $display("FAIL flush_absent got seen=%0d cnt=%0d exp 0 0", seen, bus.disp_count); end
    // Dispatch coinciding with flush still counts.
    bus.in_valid = 1'b1; bus.in_pc = 32'h400; tick();
    bus.in_pc = 32'h404; flush = 1'b1; tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.disp_count !== 32'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_dispatch got cnt=%0d valid=%b exp 1 0", bus.disp_count, bus.out_valid); end
  endtask

  task automatic test_fields();
    do_reset();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.in_instr = 32'h3508FFFF; bus.in_pc = 32'h500;
    tick();
    checks++; if (bus.imm_signed !== 1'b0 || bus.alu_src_imm !== 1'b1 || bus.imm_out !== 16'hFFFF) begin
      errors++; $display("FAIL ori_ctrl got signed=%b aluimm=%b imm=%h exp 0 1 ffff", bus.imm_signed, bus.alu_src_imm, bus.imm_out); end
    bus.in_instr = 32'h01095020;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.alu_src_imm !== 1'b0 || bus.funct !== 6'h20 || bus.rd !== 5'd10 || bus.opcode !== 6'h00) begin
      errors++; $display("FAIL rtype_fields got aluimm=%b funct=%h rd=%0d op=%h exp 0 20 10 00", bus.alu_src_imm, bus.funct, bus.rd, bus.opcode); end
    checks++; if (bus.rs !== 5'd8 || bus.rt !== 5'd9 || bus.shamt !== 5'd0 || bus.imm_signed !== 1'b1) begin
      errors++; $display("FAIL rtype_regs got rs=%0d rt=%0d shamt=%0d signed=%b exp 8 9 0 1", bus.rs, bus.rt, bus.shamt, bus.imm_signed); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ei, ep;
    logic        ev;
    logic [31:0] gi;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset_n       = ($urandom_range(0, 199) != 0);
      flush         = ($urandom_range(0, 29) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = {6'($urandom_range(0, 20)), 26'($urandom)};
      bus.in_pc     = $urandom;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
      ev = (mq_i.size() > 0);
      ei = ev ? mq_i[0] : 32'h0;
      ep = ev ? mq_p[0] : 32'h0;
      gi = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      checks++; if (bus.out_valid !== ev || bus.in_ready !== m_ready) begin
        errors++; $display("FAIL rnd_hs cyc=%0d got valid=%b ready=%b exp %b %b", c, bus.out_valid, bus.in_ready, ev, m_ready); end
      checks++; if (gi !== ei || bus.out_pc !== ep || bus.imm_out !== ei[15:0]) begin
        errors++; $display("FAIL rnd_data cyc=%0d got instr=%h pc=%h imm=%h exp %h %h %h", c, gi, bus.out_pc, bus.imm_out, ei, ep, ei[15:0]); end
      checks++; if (bus.imm_signed !== (ev && ref_imm_signed(ei)) || bus.alu_src_imm !== (ev && ref_alu_imm(ei))) begin
        errors++; $display("FAIL rnd_ctrl cyc=%0d got signed=%b aluimm=%b instr=%h", c, bus.imm_signed, bus.alu_src_imm, ei); end
      checks++; if (bus.disp_count !== m_cnt) begin
        errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, bus.disp_count, m_cnt); end
    end
    reset_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_streaming();
    test_flush();
    test_fields();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
